// File: rtl/disp_vram_pkg.sv
// Shared definitions for the display VRAM AXI read slave.
// Holds the FSM state encoding, RRESP codes, return-buffer depth,
// the beat-count width and the packed layout of one buffered R beat.
package disp_vram_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam int FIFO_DEPTH = 4;

  // ARLEN+1 reaches 256, so one extra bit over ARLEN is needed
  localparam int BEAT_CNT_W = 9;

  // One buffered R beat: 64 data bits, last flag, response code
  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

endpackage

// File: rtl/disp_rdslv_fifo.sv
// Four-entry return buffer for the VRAM read slave.
// Stores {data, last, resp} beats; the head entry is read straight out of
// the storage registers so the consumer sees first-word-fall-through data.
// Ports:
//   ACLK, ARST       clock, synchronous active-high reset
//   push_i, pushData_i  write one 67-bit beat
//   pop_i            remove the head beat (ignored when empty)
//   head_o           current head beat (all zeros after reset)
//   count_o          number of stored beats, 0..4
//   full_o, empty_o  occupancy flags
module disp_rdslv_fifo
  import disp_vram_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        push_i,
  input  logic [66:0] pushData_i,
  input  logic        pop_i,
  output logic [66:0] head_o,
  output logic [2:0]  count_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [66:0] mem_q [FIFO_DEPTH];
  logic [1:0]  wrPtr_q, rdPtr_q;
  logic [2:0]  count_q, count_d;
  logic        doPop;

  assign doPop   = pop_i && !empty_o;
  assign empty_o = (count_q == 3'd0);
  assign full_o  = (count_q == 3'(FIFO_DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A simultaneous push and pop leaves the occupancy unchanged
  always_comb begin
    count_d = count_q;
    if (push_i && !doPop) begin
      count_d = count_q + 3'd1;
    end else if (!push_i && doPop) begin
      count_d = count_q - 3'd1;
    end
  end

  // Storage is cleared on reset so the R outputs read as zero while empty
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 2'd1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  // The issue logic reserves a slot before every push, so this never fires
  noOverflow: assert property (@(posedge ACLK) disable iff (ARST) !(push_i && full_o));

endmodule

// File: rtl/disp_vram_rdslave.sv
// AXI read-channel responder for the display VRAM.
// Accepts one INCR burst at a time, reads 64-bit words from a synchronous
// single-port VRAM (data valid the cycle after MEM_RE) and streams them out
// on R through a four-beat buffer. Requests beyond the VRAM size are answered
// with DECERR beats and never touch the memory.
// Ports:
//   ACLK, ARST                 clock, synchronous active-high reset
//   ARADDR/ARLEN/ARVALID/ARREADY  read address channel
//   RDATA/RRESP/RLAST/RVALID/RREADY  read data channel
//   MEM_ADDR/MEM_RE/MEM_RDATA  VRAM port (word address)
module disp_vram_rdslave #(
  parameter int MEM_AW     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [63:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [63:0]       MEM_RDATA
);

  import disp_vram_pkg::*;

  state_t                 state_q, state_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  logic [BEAT_CNT_W-1:0]  issueCnt_q, issueCnt_d;
  logic                   err_q, err_d;
  logic [1:0]             inflight_q, inflight_d;
  logic                   pendLast_q, pendLast_d;
  logic                   pendErr_q, pendErr_d;

  logic        issue;
  logic        push;
  logic        pop;
  logic [3:0]  occupancy;
  logic [2:0]  fifoCount;
  logic        fifoEmpty;
  logic        fifoFull_unused;
  logic [2:0]  addrLsb_unused;
  beat_t       pushBeat;
  beat_t       headBeat;

  // Byte offset within the first word is ignored: bursts are word aligned
  assign addrLsb_unused = ARADDR[2:0];

  // Every issued slot (memory read or DECERR beat) spends exactly one cycle
  // in flight before it is pushed, so a slot is granted only while the
  // buffer plus the in-flight slots still have room for it
  assign occupancy = {1'b0, fifoCount} + {2'b00, inflight_q};
  assign issue     = (state_q == S_BURST) && (issueCnt_q != '0)
                     && (occupancy < 4'(FIFO_DEPTH));
  assign push      = (inflight_q != 2'd0);
  assign pop       = RVALID && RREADY;

  assign ARREADY  = (state_q == S_IDLE);
  assign MEM_RE   = issue && !err_q;
  assign MEM_ADDR = addr_q;

  // Error bursts reuse the same one-cycle slot pipeline with zeroed data
  always_comb begin
    pushBeat.data = pendErr_q ? 64'h0 : MEM_RDATA;
    pushBeat.last = pendLast_q;
    pushBeat.resp = pendErr_q ? RRESP_DECERR : RRESP_OKAY;
  end

  assign RVALID = !fifoEmpty;
  assign RDATA  = headBeat.data;
  assign RLAST  = headBeat.last;
  assign RRESP  = headBeat.resp;

  disp_rdslv_fifo uFifo (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .push_i     (push),
    .pushData_i (pushBeat),
    .pop_i      (pop),
    .head_o     (headBeat),
    .count_o    (fifoCount),
    .full_o     (fifoFull_unused),
    .empty_o    (fifoEmpty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issueCnt_d = issueCnt_q;
    err_d      = err_q;
    inflight_d = inflight_q + {1'b0, issue} - {1'b0, push};
    pendLast_d = issue && (issueCnt_q == BEAT_CNT_W'(1));
    pendErr_d  = err_q;

    case (state_q)
      S_IDLE: begin
        if (ARVALID) begin
          state_d    = S_BURST;
          addr_d     = ARADDR[MEM_AW+2:3];
          issueCnt_d = BEAT_CNT_W'(ARLEN) + BEAT_CNT_W'(1);
          err_d      = |ARADDR[31:MEM_AW+3];
        end
      end
      S_BURST: begin
        // Address wraps modulo the VRAM size; no 4 KB boundary handling
        if (issue) begin
          addr_d     = addr_q + MEM_AW'(1);
          issueCnt_d = issueCnt_q - BEAT_CNT_W'(1);
        end
        if (pop && RLAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      issueCnt_q <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
      pendLast_q <= 1'b0;
      pendErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issueCnt_q <= issueCnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      pendLast_q <= pendLast_d;
      pendErr_q  <= pendErr_d;
    end
  end

endmodule

// File: tb/tb_disp_vram_rdslave.sv
// Self-checking bench for disp_vram_rdslave: a behavioural VRAM, a
// burst-level reference model and a beat scoreboard.
module tb_disp_vram_rdslave;

  localparam int MEM_AW = 16;
  localparam int VRAM_WORDS = 65536;

  logic              ACLK = 1'b0;
  logic              ARST;
  logic [31:0]       ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [63:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic [MEM_AW-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic [63:0]       MEM_RDATA = 64'h0;

  disp_vram_rdslave #(.MEM_AW(MEM_AW), .FIFO_DEPTH(4)) dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RE    (MEM_RE),
    .MEM_RDATA (MEM_RDATA)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural synchronous VRAM
  logic [63:0] vram [VRAM_WORDS];
  always @(posedge ACLK) begin
    if (MEM_RE) MEM_RDATA <= vram[MEM_ADDR];
  end

  int errCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected beats {data,last,resp} and expected VRAM word addresses
  logic [66:0] expQ[$];
  logic [15:0] addrQ[$];

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int issued = 0;
  int poppedOk = 0;
  int burstBeats = 0;
  int memReInBurst = 0;
  int firstMemRe = -1;
  int firstRvalid = -1;
  int lastBeat = -1;
  int readyRise = -1;
  int hsCyc = 0;
  bit trackReady = 0;
  bit prevStall = 0;
  bit randReady = 0;
  logic [66:0] prevHead = '0;

  // Monitor and scoreboard, sampling on the falling edge
  always @(negedge ACLK) begin
    if (ARST) begin
      prevStall = 0;
    end else begin
      if (MEM_RE) begin
        issued++;
        memReInBurst++;
        if (firstMemRe < 0) firstMemRe = cyc;
        if (addrQ.size() == 0) checkOutput("memReUnexpected", MEM_RE, 1'b0);
        else checkOutput("memAddr", MEM_ADDR, addrQ.pop_front());
        checkOutput("outstandingMax4", (issued - poppedOk) <= 4, 1'b1);
      end
      if (RVALID && firstRvalid < 0) firstRvalid = cyc;
      if (prevStall) begin
        checkOutput("stallValid", RVALID, 1'b1);
        checkOutput("stallHold", {RDATA, RLAST, RRESP}, prevHead);
      end
      if (RVALID && RREADY) begin
        if (expQ.size() == 0) checkOutput("beatUnexpected", RVALID, 1'b0);
        else checkOutput("beat", {RDATA, RLAST, RRESP}, expQ.pop_front());
        burstBeats++;
        if (RRESP == 2'b00) poppedOk++;
        if (RLAST) lastBeat = cyc;
      end
      if (trackReady && ARREADY) begin
        readyRise = cyc;
        trackReady = 0;
      end
      prevStall = RVALID && !RREADY;
      prevHead = {RDATA, RLAST, RRESP};
    end
  end

  // RREADY driver: always high or a coin toss each cycle
  initial begin
    RREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      RREADY = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Issues one AR request and loads the reference model with its beats
  task automatic applyStimulus(input logic [31:0] addr, input int len);
    bit outOfRange;
    int unsigned base;
    int unsigned w;
    @(posedge ACLK);
    #1;
    checkOutput("arreadyIdle", ARREADY, 1'b1);
    outOfRange = (addr >= 32'h0008_0000);
    base = addr / 8;
    for (int i = 0; i <= len; i++) begin
      if (outOfRange) begin
        expQ.push_back({64'h0, 1'(i == len), 2'b11});
      end else begin
        w = (base + i) % VRAM_WORDS;
        expQ.push_back({vram[w], 1'(i == len), 2'b00});
        addrQ.push_back(16'(w));
      end
    end
    firstMemRe = -1;
    firstRvalid = -1;
    lastBeat = -1;
    burstBeats = 0;
    memReInBurst = 0;
    ARADDR = addr;
    ARLEN = 8'(len);
    ARVALID = 1'b1;
    @(posedge ACLK);
    #1;
    hsCyc = cyc;
    ARVALID = 1'b0;
    trackReady = 1;
  endtask

  task automatic waitIdle(input int maxCyc, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge ACLK);
      #1;
      if (expQ.size() == 0 && ARREADY) begin
        done = 1;
        break;
      end
    end
    checkOutput({tag, "Complete"}, done, 1'b1);
    checkOutput({tag, "AddrDrained"}, addrQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int len;
    bit sawFive;

    for (int i = 0; i < VRAM_WORDS; i++) vram[i] = {$urandom, $urandom};
    vram[8] = 64'h0123_4567_89AB_CDEF;

    ARST = 1'b1;
    ARVALID = 1'b0;
    ARADDR = '0;
    ARLEN = '0;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("rstArready", ARREADY, 1'b1);
    checkOutput("rstRvalid", RVALID, 1'b0);
    checkOutput("rstRlast", RLAST, 1'b0);
    checkOutput("rstRresp", RRESP, 2'b00);
    checkOutput("rstRdata", RDATA, 64'h0);
    checkOutput("rstMemRe", MEM_RE, 1'b0);
    checkOutput("rstMemAddr", MEM_ADDR, 16'h0);
    ARST = 1'b0;

    $display("[TB] single beat");
    applyStimulus(32'h40, 0);
    waitIdle(50, "single");
    checkOutput("singleMemReLat", firstMemRe, hsCyc);
    checkOutput("singleRvalidLat", firstRvalid, hsCyc + 2);
    checkOutput("singleBeats", burstBeats, 1);

    $display("[TB] full-rate burst");
    applyStimulus(32'h100, 15);
    waitIdle(100, "fullRate");
    checkOutput("fullRvalidLat", firstRvalid, hsCyc + 2);
    checkOutput("fullLastBeat", lastBeat, hsCyc + 17);
    checkOutput("fullReadyRise", readyRise, hsCyc + 18);
    checkOutput("fullBeats", burstBeats, 16);

    $display("[TB] back-pressure burst with ARVALID held mid-burst");
    randReady = 1;
    applyStimulus(32'h100, 15);
    repeat (3) @(posedge ACLK);
    #1;
    ARADDR = 32'h200;
    ARLEN = 8'd2;
    ARVALID = 1'b1;
    repeat (4) @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    waitIdle(400, "backPressure");
    checkOutput("bpBeats", burstBeats, 16);

    $display("[TB] out of range");
    randReady = 0;
    applyStimulus(32'h0008_0000, 3);
    waitIdle(100, "outOfRange");
    checkOutput("oorNoMemRe", memReInBurst, 0);
    checkOutput("oorBeats", burstBeats, 4);

    $display("[TB] address wrap");
    applyStimulus(32'h0007_FFF0, 3);
    waitIdle(100, "wrap");
    checkOutput("wrapMemReCount", memReInBurst, 4);

    $display("[TB] reset mid-burst");
    applyStimulus(32'h400, 15);
    sawFive = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge ACLK);
      #1;
      if (burstBeats >= 5) begin
        sawFive = 1;
        break;
      end
    end
    checkOutput("midResetReached5", sawFive, 1'b1);
    ARST = 1'b1;
    @(posedge ACLK);
    #1;
    checkOutput("midResetRvalid", RVALID, 1'b0);
    checkOutput("midResetArready", ARREADY, 1'b1);
    checkOutput("midResetMemRe", MEM_RE, 1'b0);
    checkOutput("midResetRdata", RDATA, 64'h0);
    expQ.delete();
    addrQ.delete();
    issued = 0;
    poppedOk = 0;
    ARST = 1'b0;
    applyStimulus(32'h48, 0);
    waitIdle(50, "afterReset");
    checkOutput("afterResetBeats", burstBeats, 1);
    checkOutput("afterResetRvalidLat", firstRvalid, hsCyc + 2);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h0007_FFFF;
      len = $urandom_range(0, 20);
      randReady = 1'($urandom_range(0, 1));
      applyStimulus(a, len);
      waitIdle(600, "random");
      checkOutput("randomBeats", burstBeats, len + 1);
      if (a >= 32'h0008_0000) checkOutput("randomOorNoMemRe", memReInBurst, 0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
